alarm_ctrl: RTL and testbench



---
 rtl/alarm_ctrl_if.sv | 24 ++
 rtl/alarm_ctrl.sv | 106 ++++++++++
 tb/tb_alarm_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock/alarm-set datapath and the alarm sequencer.
// The master side drives time, alarm setting and buttons; the slave side returns buzz/snooze status.
interface alarm_ctrl_if;
  logic [6:0] tsec;
  logic [6:0] tmin;
  logic [6:0] thrs;
  logic [6:0] amin;
  logic [6:0] ahrs;
  logic       alarmon;
  logic       snooze;
  logic       buzz;
  logic       snoozing;
  logic [1:0] snz_cnt;

  modport master (
    output tsec, tmin, thrs, amin, ahrs, alarmon, snooze,
    input  buzz, snoozing, snz_cnt
  );

  modport slave (
    input  tsec, tmin, thrs, amin, ahrs, alarmon, snooze,
    output buzz, snoozing, snz_cnt
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: fires a single ring at hh:mm:00 of the alarm setting, with bounded snooze
// and ring auto-off. Clocked by the 1 Hz pulse, so one cycle is one second.
module alarm_ctrl #(
  parameter int unsigned NS       = 60,
  parameter int unsigned NH       = 24,
  parameter int unsigned SNZ_MIN  = 9,
  parameter int unsigned RING_SEC = 60,
  parameter int unsigned MAX_SNZ  = 3
) (
  input  logic         clk,
  input  logic         rst,
  alarm_ctrl_if.slave  bus
);

  localparam int unsigned SNZ_LEN = SNZ_MIN * NS;
  localparam int unsigned RING_W  = $clog2(RING_SEC);
  localparam int unsigned SNZ_W   = $clog2(SNZ_LEN);

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNZ_LEN - 1);
  localparam logic [1:0]        MAX_C     = 2'(MAX_SNZ);
  localparam logic [6:0]        NS_C      = 7'(NS);
  localparam logic [6:0]        NH_C      = 7'(NH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [RING_W-1:0] ring_ct_q, ring_ct_d;
  logic [SNZ_W-1:0]  snz_ct_q, snz_ct_d;
  logic [1:0]        snz_cnt_q, snz_cnt_d;
  logic              buzz_q, snoozing_q;
  logic              match_c;

  // Out-of-range time can never match, even if the alarm setting is equally out of range.
  assign match_c = (bus.tsec == 7'd0) && (bus.tmin == bus.amin) && (bus.thrs == bus.ahrs)
                   && (bus.tmin < NS_C) && (bus.thrs < NH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ring_ct_q  <= '0;
      snz_ct_q   <= '0;
      snz_cnt_q  <= '0;
      buzz_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_ct_q  <= ring_ct_d;
      snz_ct_q   <= snz_ct_d;
      snz_cnt_q  <= snz_cnt_d;
      buzz_q     <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  // Next-state and counter update; match is only looked at in IDLE so an event cannot restart.
  always_comb begin
    state_d   = state_q;
    ring_ct_d = ring_ct_q;
    snz_ct_d  = snz_ct_q;
    snz_cnt_d = snz_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.alarmon && match_c) begin
          state_d   = RING;
          ring_ct_d = '0;
          snz_cnt_d = '0;
        end
      end
      RING: begin
        if (!bus.alarmon) begin
          state_d = IDLE;
        end else if (bus.snooze && (snz_cnt_q < MAX_C)) begin
          state_d   = SNOOZE;
          snz_ct_d  = SNZ_LAST;
          snz_cnt_d = snz_cnt_q + 2'd1;
        end else if (ring_ct_q == RING_LAST) begin
          state_d = IDLE;
        end else begin
          ring_ct_d = ring_ct_q + RING_W'(1);
        end
      end
      SNOOZE: begin
        if (!bus.alarmon) begin
          state_d   = IDLE;
          snz_cnt_d = '0;
        end else if (snz_ct_q == '0) begin
          state_d   = RING;
          ring_ct_d = '0;
        end else begin
          snz_ct_d = snz_ct_q - SNZ_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.buzz     = buzz_q;
  assign bus.snoozing = snoozing_q;
  assign bus.snz_cnt  = snz_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: stimulus pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_ctrl_if bus ();

  alarm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int         test;
    int         cyc;
    logic       buzz;
    logic       snoozing;
    logic [1:0] snz_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cur_test = 0;
  int   cur_cyc = 0;

  // Monitor: one expected entry per clocked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.buzz !== e.buzz || bus.snoozing !== e.snoozing || bus.snz_cnt !== e.snz_cnt) begin
        errors++;
        $display("FAIL t%0d cyc%0d: buzz/snoozing/snz_cnt got %b/%b/%0d want %b/%b/%0d",
                 e.test, e.cyc, bus.buzz, bus.snoozing, bus.snz_cnt, e.buzz, e.snoozing, e.snz_cnt);
      end
    end
  end

  task automatic set_time(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    bus.thrs = h;
    bus.tmin = m;
    bus.tsec = s;
  endtask

  // Clock one edge with the current inputs and queue the outputs expected after it.
  task automatic tick(input logic eb, input logic es, input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    cur_cyc++;
    e.test = cur_test;
    e.cyc = cur_cyc;
    e.buzz = eb;
    e.snoozing = es;
    e.snz_cnt = ec;
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n, input logic eb, input logic es, input logic [1:0] ec);
    for (int i = 0; i < n; i++) tick(eb, es, ec);
  endtask

  // Apply 07:30:00 for one edge, then move the clock off the match.
  task automatic trigger(input logic [1:0] ec);
    set_time(7'd7, 7'd30, 7'd0);
    tick(1'b1, 1'b0, ec);
    set_time(7'd7, 7'd30, 7'd1);
  endtask

  task automatic begin_test(input int t);
    cur_test = t;
    cur_cyc = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.amin = 7'd0;
    bus.ahrs = 7'd0;
    bus.alarmon = 1'b1;
    bus.snooze = 1'b1;
    set_time(7'd0, 7'd0, 7'd0);
    @(negedge clk);

    // 1: reset with a matching time, then a plain 60-cycle ring
    begin_test(1);
    ticks(2, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    bus.snooze = 1'b0;
    bus.amin = 7'd30;
    bus.ahrs = 7'd7;
    set_time(7'd7, 7'd29, 7'd59);
    tick(1'b0, 1'b0, 2'd0);
    trigger(2'd0);
    ticks(59, 1'b1, 1'b0, 2'd0);
    ticks(3, 1'b0, 1'b0, 2'd0);

    // 2: alarm disabled at the match second, enabling late must not fire
    begin_test(2);
    bus.alarmon = 1'b0;
    set_time(7'd7, 7'd30, 7'd0);
    tick(1'b0, 1'b0, 2'd0);
    bus.alarmon = 1'b1;
    set_time(7'd7, 7'd30, 7'd1);
    ticks(5, 1'b0, 1'b0, 2'd0);

    // 3: snooze at ring cycle 5, 540-cycle gap, then a full ring
    begin_test(3);
    trigger(2'd0);
    ticks(4, 1'b1, 1'b0, 2'd0);
    bus.snooze = 1'b1;
    tick(1'b0, 1'b1, 2'd1);
    bus.snooze = 1'b0;
    ticks(539, 1'b0, 1'b1, 2'd1);
    ticks(60, 1'b1, 1'b0, 2'd1);
    ticks(3, 1'b0, 1'b0, 2'd1);

    // 4: three snoozes accepted, fourth ignored until auto-off
    begin_test(4);
    trigger(2'd0);
    for (int k = 1; k <= 3; k++) begin
      bus.snooze = 1'b1;
      tick(1'b0, 1'b1, 2'(k));
      bus.snooze = 1'b0;
      ticks(539, 1'b0, 1'b1, 2'(k));
      tick(1'b1, 1'b0, 2'(k));
    end
    bus.snooze = 1'b1;
    ticks(59, 1'b1, 1'b0, 2'd3);
    ticks(2, 1'b0, 1'b0, 2'd3);
    bus.snooze = 1'b0;

    // 5: dropping alarmon mid-snooze ends the event and clears the count
    begin_test(5);
    trigger(2'd0);
    bus.snooze = 1'b1;
    tick(1'b0, 1'b1, 2'd1);
    bus.snooze = 1'b0;
    ticks(100, 1'b0, 1'b1, 2'd1);
    bus.alarmon = 1'b0;
    tick(1'b0, 1'b0, 2'd0);
    bus.alarmon = 1'b1;
    ticks(445, 1'b0, 1'b0, 2'd0);

    // 6: alarm-setting change during ring is ignored; reset mid-ring; no re-fire until next match
    begin_test(6);
    trigger(2'd0);
    bus.amin = 7'd31;
    ticks(3, 1'b1, 1'b0, 2'd0);
    bus.amin = 7'd30;
    rst = 1'b1;
    tick(1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    ticks(70, 1'b0, 1'b0, 2'd0);
    set_time(7'd8, 7'd30, 7'd0);
    tick(1'b0, 1'b0, 2'd0);
    trigger(2'd0);
    tick(1'b1, 1'b0, 2'd0);
    bus.alarmon = 1'b0;
    ticks(2, 1'b0, 1'b0, 2'd0);

    // Let the monitor drain; a stuck queue counts as a failed check.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending entries got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
